// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: programmable pixel-clock divider, sync/blank decode,
// line/frame start pulses and a wrapping frame counter, all frozen while en is low.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned DIV      = 4,
  parameter int unsigned HS_POL   = 0,
  parameter int unsigned VS_POL   = 0,
  parameter int unsigned XW       = 10,
  parameter int unsigned YW       = 10,
  parameter int unsigned FW       = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic          p_tick,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [XW-1:0] pixel_x,
  output logic [YW-1:0] pixel_y,
  output logic          sol,
  output logic          sof,
  output logic [FW-1:0] frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DW      = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
  localparam logic [XW-1:0] X_ACT    = XW'(H_ACTIVE);
  localparam logic [YW-1:0] Y_ACT    = YW'(V_ACTIVE);
  localparam logic [XW-1:0] HS_FIRST = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_LAST  = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [YW-1:0] VS_FIRST = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_LAST  = YW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic          HS_ON    = (HS_POL != 0);
  localparam logic          VS_ON    = (VS_POL != 0);

  logic [DW-1:0] div_q, div_d;
  logic [XW-1:0] x_q, x_d, x_nxt;
  logic [YW-1:0] y_q, y_d, y_nxt;
  logic          hs_q, hs_d, vs_q, vs_d, vo_q, vo_d;
  logic          sol_q, sol_d, sof_q, sof_d;
  logic [FW-1:0] fc_q, fc_d;

  assign p_tick    = en & (div_q == DIV_LAST);
  assign hsync     = hs_q;
  assign vsync     = vs_q;
  assign video_on  = vo_q;
  assign pixel_x   = x_q;
  assign pixel_y   = y_q;
  assign sol       = sol_q;
  assign sof       = sof_q;
  assign frame_cnt = fc_q;

  // Next raster position and its decodes, so every output lines up with the new coordinate.
  always_comb begin
    div_d = div_q;
    x_d   = x_q;
    y_d   = y_q;
    x_nxt = x_q;
    y_nxt = y_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    vo_d  = vo_q;
    fc_d  = fc_q;
    sol_d = 1'b0;
    sof_d = 1'b0;

    if (en) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
    end

    if (p_tick) begin
      if (x_q == X_LAST) begin
        x_nxt = '0;
        y_nxt = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
      end else begin
        x_nxt = x_q + XW'(1);
      end
      x_d   = x_nxt;
      y_d   = y_nxt;
      hs_d  = ((x_nxt >= HS_FIRST) && (x_nxt <= HS_LAST)) ? HS_ON : ~HS_ON;
      vs_d  = ((y_nxt >= VS_FIRST) && (y_nxt <= VS_LAST)) ? VS_ON : ~VS_ON;
      vo_d  = (x_nxt < X_ACT) && (y_nxt < Y_ACT);
      sol_d = (x_nxt == '0);
      sof_d = (x_nxt == '0) && (y_nxt == '0);
      if (sof_d) begin
        fc_d = fc_q + FW'(1);
      end
    end
  end

  // Reset parks the raster on the last position so the first tick enters (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      x_q   <= X_LAST;
      y_q   <= Y_LAST;
      hs_q  <= ~HS_ON;
      vs_q  <= ~VS_ON;
      vo_q  <= 1'b0;
      sol_q <= 1'b0;
      sof_q <= 1'b0;
      fc_q  <= '0;
    end else begin
      div_q <= div_d;
      x_q   <= x_d;
      y_q   <= y_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      vo_q  <= vo_d;
      sol_q <= sol_d;
      sof_q <= sof_d;
      fc_q  <= fc_d;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default, tiny DIV=1 active-high, small DIV=3)
// checked against a position-from-tick-count reference model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int    total = 0;
  int    bad   = 0;
  longint cyc  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: defaults
  logic rst_a, en_a, p_a, hs_a, vs_a, vo_a, sol_a, sof_a;
  logic [9:0] x_a, y_a;
  logic [15:0] fc_a;
  vga_timing_gen u_a (
    .clk(clk), .rst_n(rst_a), .en(en_a), .p_tick(p_a), .hsync(hs_a), .vsync(vs_a),
    .video_on(vo_a), .pixel_x(x_a), .pixel_y(y_a), .sol(sol_a), .sof(sof_a), .frame_cnt(fc_a));

  // Instance B: tiny timing, DIV=1, active-high syncs, 2-bit frame counter
  logic rst_b, en_b, p_b, hs_b, vs_b, vo_b, sol_b, sof_b;
  logic [2:0] x_b, y_b;
  logic [1:0] fc_b;
  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1), .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .DIV(1), .HS_POL(1), .VS_POL(1), .XW(3), .YW(3), .FW(2)
  ) u_b (
    .clk(clk), .rst_n(rst_b), .en(en_b), .p_tick(p_b), .hsync(hs_b), .vsync(vs_b),
    .video_on(vo_b), .pixel_x(x_b), .pixel_y(y_b), .sol(sol_b), .sof(sof_b), .frame_cnt(fc_b));

  // Instance C: small timing, DIV=3, active-low syncs
  logic rst_c, en_c, p_c, hs_c, vs_c, vo_c, sol_c, sof_c;
  logic [3:0] x_c, y_c;
  logic [3:0] fc_c;
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .DIV(3), .XW(4), .YW(4), .FW(4)
  ) u_c (
    .clk(clk), .rst_n(rst_c), .en(en_c), .p_tick(p_c), .hsync(hs_c), .vsync(vs_c),
    .video_on(vo_c), .pixel_x(x_c), .pixel_y(y_c), .sol(sol_c), .sof(sof_c), .frame_cnt(fc_c));

  // Model state: enabled clocks since reset, and whether the last edge was a pixel tick
  longint ec_a, ec_b, ec_c;
  bit     tk_a, tk_b, tk_c;

  always @(posedge clk or negedge rst_a)
    if (!rst_a) begin ec_a <= 0; tk_a <= 1'b0; end
    else if (en_a) begin tk_a <= (ec_a % 4 == 3); ec_a <= ec_a + 1; end
    else tk_a <= 1'b0;

  always @(posedge clk or negedge rst_b)
    if (!rst_b) begin ec_b <= 0; tk_b <= 1'b0; end
    else if (en_b) begin tk_b <= 1'b1; ec_b <= ec_b + 1; end
    else tk_b <= 1'b0;

  always @(posedge clk or negedge rst_c)
    if (!rst_c) begin ec_c <= 0; tk_c <= 1'b0; end
    else if (en_c) begin tk_c <= (ec_c % 3 == 2); ec_c <= ec_c + 1; end
    else tk_c <= 1'b0;

  // Position = (ticks-1) mod frame size; ticks = enabled clocks / DIV.
  function automatic logic [53:0] model(input int ha, input int hfp, input int hsw, input int hbp,
                                        input int va, input int vfp, input int vsw, input int vbp,
                                        input int div, input bit hpol, input bit vpol, input int fw,
                                        input longint ec, input bit tk, input bit en_now);
    int ht = ha + hfp + hsw + hbp;
    int vt = va + vfp + vsw + vbp;
    longint n = ec / div;
    longint pos, fc;
    int x, y;
    bit p, hs, vs, vo, sl, sf;
    p = en_now && (ec % div == longint'(div - 1));
    if (n == 0) begin
      x = ht - 1; y = vt - 1; vo = 1'b0; hs = !hpol; vs = !vpol; sl = 1'b0; sf = 1'b0; fc = 0;
    end else begin
      pos = (n - 1) % longint'(ht * vt);
      x   = int'(pos % ht);
      y   = int'(pos / ht);
      vo  = (x < ha) && (y < va);
      hs  = (x >= ha + hfp && x < ha + hfp + hsw) ? hpol : !hpol;
      vs  = (y >= va + vfp && y < va + vfp + vsw) ? vpol : !vpol;
      sl  = tk && (x == 0);
      sf  = sl && (y == 0);
      fc  = ((n - 1) / longint'(ht * vt) + 1) % (longint'(1) << fw);
    end
    return {p, hs, vs, vo, sl, sf, 16'(x), 16'(y), 16'(fc)};
  endfunction

  function automatic logic [53:0] exp_a();
    return model(640, 16, 96, 48, 480, 10, 2, 33, 4, 1'b0, 1'b0, 16, ec_a, tk_a, en_a);
  endfunction
  function automatic logic [53:0] exp_b();
    return model(4, 1, 1, 1, 3, 1, 1, 1, 1, 1'b1, 1'b1, 2, ec_b, tk_b, en_b);
  endfunction
  function automatic logic [53:0] exp_c();
    return model(8, 2, 3, 2, 5, 1, 2, 1, 3, 1'b0, 1'b0, 4, ec_c, tk_c, en_c);
  endfunction
  function automatic logic [53:0] obs_a();
    return {p_a, hs_a, vs_a, vo_a, sol_a, sof_a, 16'(x_a), 16'(y_a), 16'(fc_a)};
  endfunction
  function automatic logic [53:0] obs_b();
    return {p_b, hs_b, vs_b, vo_b, sol_b, sof_b, 16'(x_b), 16'(y_b), 16'(fc_b)};
  endfunction
  function automatic logic [53:0] obs_c();
    return {p_c, hs_c, vs_c, vo_c, sol_c, sof_c, 16'(x_c), 16'(y_c), 16'(fc_c)};
  endfunction

  longint last_sol_a;

  task automatic test_reset();
    int k = 0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (obs_a() !== exp_a()) begin
      bad++; $display("FAIL reset_model: got=%h want=%h", obs_a(), exp_a());
    end
    total++;
    if ({p_a, hs_a, vs_a, vo_a, sol_a, sof_a} !== 6'b011000 || x_a !== 10'd799 ||
        y_a !== 10'd524 || fc_a !== 16'd0) begin
      bad++;
      $display("FAIL reset_values: p/hs/vs/vo/sol/sof=%b%b%b%b%b%b x=%0d y=%0d fc=%0d want 011000 799 524 0",
               p_a, hs_a, vs_a, vo_a, sol_a, sof_a, x_a, y_a, fc_a);
    end
    @(negedge clk) rst_a = 1'b1;
    while (p_a !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    total++;
    if (k != 3) begin bad++; $display("FAIL first_tick_delay: clocks=%0d want 3", k); end
    @(posedge clk); #1;
    last_sol_a = cyc;
    total++;
    if (x_a !== 10'd0 || y_a !== 10'd0 || sof_a !== 1'b1 || sol_a !== 1'b1 || vo_a !== 1'b1 ||
        fc_a !== 16'd1) begin
      bad++;
      $display("FAIL first_tick: x=%0d y=%0d sof=%b sol=%b vo=%b fc=%0d want 0 0 1 1 1 1",
               x_a, y_a, sof_a, sol_a, vo_a, fc_a);
    end
    @(posedge clk); #1;
    total++;
    if (sol_a !== 1'b0 || sof_a !== 1'b0 || x_a !== 10'd0 || obs_a() !== exp_a()) begin
      bad++; $display("FAIL pulse_width: sol=%b sof=%b x=%0d want 0 0 0", sol_a, sof_a, x_a);
    end
  endtask

  task automatic test_line();
    int errs = 0, ticks = 0, hlow = 0, voff = 0, i = 0;
    bit prev_p = p_a, seen = 1'b0;
    longint period = 0;
    while (!seen && i < 4000) begin
      @(posedge clk); #1; i++;
      if (obs_a() !== exp_a()) errs++;
      if (prev_p) begin
        ticks++;
        if (hs_a === 1'b0) hlow++;
        if (vo_a === 1'b0) voff++;
      end
      if (sol_a === 1'b1) begin seen = 1'b1; period = cyc - last_sol_a; last_sol_a = cyc; end
      prev_p = p_a;
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL line_model: mismatches=%0d want 0", errs); end
    total++;
    if (period != 3200 || ticks != 800) begin
      bad++; $display("FAIL sol_period: clocks=%0d ticks=%0d want 3200 800", period, ticks);
    end
    total++;
    if (hlow != 96) begin bad++; $display("FAIL hsync_width: ticks=%0d want 96", hlow); end
    total++;
    if (voff != 160) begin bad++; $display("FAIL blank_width: ticks=%0d want 160", voff); end
  endtask

  task automatic test_freeze();
    int errs = 0, i = 0, k = 0;
    bit prev_p = p_a, found = 1'b0;
    while (!found && i < 1000) begin
      @(posedge clk); #1; i++;
      if (obs_a() !== exp_a()) errs++;
      found = prev_p && (x_a === 10'd100);
      prev_p = p_a;
    end
    total++;
    if (!found || errs != 0) begin
      bad++; $display("FAIL freeze_approach: found=%0d mismatches=%0d want 1 0", found, errs);
    end
    en_a = 1'b0;
    errs = 0;
    repeat (37) begin
      @(posedge clk); #1;
      if (obs_a() !== exp_a() || p_a !== 1'b0 || x_a !== 10'd100 || y_a !== 10'd1) errs++;
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL freeze_hold: mismatches=%0d want 0", errs); end
    en_a = 1'b1;
    prev_p = 1'b0;
    while (!prev_p && k < 10) begin
      prev_p = p_a;
      @(posedge clk); #1; k++;
    end
    total++;
    if (x_a !== 10'd101 || k != 4 || obs_a() !== exp_a()) begin
      bad++; $display("FAIL freeze_resume: x=%0d clocks=%0d want 101 4", x_a, k);
    end
  endtask

  task automatic test_reset_midframe();
    int errs = 0, i = 0;
    bit prev_p = p_a, found = 1'b0;
    while (!found && i < 4000) begin
      @(posedge clk); #1; i++;
      if (obs_a() !== exp_a()) errs++;
      found = prev_p && (x_a === 10'd700);
      prev_p = p_a;
    end
    total++;
    if (!found || errs != 0) begin
      bad++; $display("FAIL rst_approach: found=%0d mismatches=%0d want 1 0", found, errs);
    end
    #2 rst_a = 1'b0;
    #1;
    total++;
    if (x_a !== 10'd799 || y_a !== 10'd524 || hs_a !== 1'b1 || vs_a !== 1'b1 || vo_a !== 1'b0 ||
        sol_a !== 1'b0 || sof_a !== 1'b0 || fc_a !== 16'd0 || p_a !== 1'b0 || obs_a() !== exp_a()) begin
      bad++;
      $display("FAIL async_reset: x=%0d y=%0d hs=%b vs=%b vo=%b fc=%0d want 799 524 1 1 0 0",
               x_a, y_a, hs_a, vs_a, vo_a, fc_a);
    end
    @(posedge clk); #1;
    rst_a = 1'b1;
    total++;
    if (x_a !== 10'd799 || obs_a() !== exp_a()) begin
      bad++; $display("FAIL reset_held: x=%0d want 799", x_a);
    end
  endtask

  task automatic test_tiny();
    int errs = 0, perr = 0, herr = 0;
    bit prev_p;
    logic [1:0] seq[$];
    total++;
    if (obs_b() !== exp_b() || hs_b !== 1'b0 || vs_b !== 1'b0) begin
      bad++; $display("FAIL tiny_reset: got=%h want=%h", obs_b(), exp_b());
    end
    rst_b = 1'b1;
    en_b  = 1'b1;
    #1;
    prev_p = p_b;
    for (int i = 0; i < 420; i++) begin
      @(posedge clk); #1;
      if (obs_b() !== exp_b()) errs++;
      if (en_b && p_b !== 1'b1) perr++;
      if (prev_p && hs_b === 1'b1 && x_b !== 3'd5) herr++;
      if (prev_p && hs_b === 1'b0 && x_b === 3'd5) herr++;
      if (sof_b === 1'b1) seq.push_back(fc_b);
      en_b = (i < 30) ? 1'b1 : ($urandom_range(3) != 0);
      #1;
      prev_p = p_b;
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL tiny_model: mismatches=%0d want 0", errs); end
    total++;
    if (perr != 0) begin bad++; $display("FAIL tiny_ptick: low_while_enabled=%0d want 0", perr); end
    total++;
    if (herr != 0) begin bad++; $display("FAIL tiny_hsync: wrong_ticks=%0d want 0", herr); end
    total++;
    if (seq.size() < 5 || seq[0] !== 2'd1 || seq[1] !== 2'd2 || seq[2] !== 2'd3 ||
        seq[3] !== 2'd0 || seq[4] !== 2'd1) begin
      bad++; $display("FAIL frame_wrap: got %p want 1,2,3,0,1", seq);
    end
  endtask

  task automatic test_mid_frame();
    int errs = 0, nsof = 0, vlow = 0, i = 0;
    bit prev_p;
    longint sof1 = 0, period = 0;
    logic [3:0] fc1 = '0, fc2 = '0;
    rst_c = 1'b1;
    en_c  = 1'b1;
    #1;
    prev_p = p_c;
    while (nsof < 2 && i < 1000) begin
      @(posedge clk); #1; i++;
      if (obs_c() !== exp_c()) errs++;
      if (sof_c === 1'b1) begin
        nsof++;
        if (nsof == 1) begin sof1 = cyc; fc1 = fc_c; end
        else begin period = cyc - sof1; fc2 = fc_c; end
      end
      if (prev_p && nsof == 1 && vs_c === 1'b0) vlow++;
      prev_p = p_c;
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL mid_model: mismatches=%0d want 0", errs); end
    total++;
    if (period != 405 || fc1 !== 4'd1 || fc2 !== 4'd2) begin
      bad++; $display("FAIL sof_period: clocks=%0d fc=%0d,%0d want 405 1,2", period, fc1, fc2);
    end
    total++;
    if (vlow != 30) begin bad++; $display("FAIL vsync_width: ticks=%0d want 30", vlow); end
  endtask

  task automatic test_mid_random();
    int errs = 0, rerrs = 0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (obs_c() !== exp_c()) errs++;
      if (rst_c == 1'b0) rst_c = 1'b1;
      else if ($urandom_range(59) == 0) begin
        #2 rst_c = 1'b0;
        #1;
        if (obs_c() !== exp_c() || x_c !== 4'd14 || y_c !== 4'd8 || fc_c !== 4'd0) rerrs++;
      end
      en_c = ($urandom_range(2) != 0);
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL random_model: mismatches=%0d want 0", errs); end
    total++;
    if (rerrs != 0) begin bad++; $display("FAIL random_reset: mismatches=%0d want 0", rerrs); end
  endtask

  initial begin
    rst_a = 1'b0; en_a = 1'b1;
    rst_b = 1'b0; en_b = 1'b0;
    rst_c = 1'b0; en_c = 1'b0;
    test_reset();
    test_line();
    test_freeze();
    test_reset_midframe();
    test_tiny();
    test_mid_frame();
    test_mid_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
